q1_control: RTL and testbench

Upstream command stage for the up/down counter pair. Turns two raw push-buttons (start/stop and swap) into the single-cycle `enable` and `swap` strobes the counter stage consumes. Each button is synchronised and debounced, and only its rising edge counts as a press. A run/stop state machine with a prescaler paces `enable` so the counters step at a visible rate.

---
 rtl/q1_control.sv | 169 ++++++++++++++++
 tb/tb_q1_control.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q1_control.sv
// Command stage for the up/down counter pair: debounced start/stop and swap buttons drive
// a run/stop FSM whose prescaler paces the enable/swap strobes. Define Q1CTRL_STEP_EN to add stepBtn.
module q1_control #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 100,
    parameter int CNT_WIDTH       = 8
) (
    input  logic clock,
    input  logic resetN,
    input  logic startStopBtn,
    input  logic swapBtn,
`ifdef Q1CTRL_STEP_EN
    input  logic stepBtn,
`endif
    output logic enable,
    output logic swap,
    output logic running
);

`ifdef Q1CTRL_STEP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    localparam int BTN_SS = 0;
    localparam int BTN_SW = 1;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PRESC_LAST = CNT_WIDTH'(TICK_DIV - 1);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    logic [NB-1:0]        w_raw;
    logic [NB-1:0]        r_sync1;
    logic [NB-1:0]        r_sync2;
    logic [NB-1:0]        r_deb;
    logic [NB-1:0]        r_deb_d;
    logic [CNT_WIDTH-1:0] r_deb_cnt [NB];
    logic [NB-1:0]        w_press;

    logic                 w_ss_press;
    logic                 w_sw_press;
    logic                 w_step_press;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_presc;
    logic [CNT_WIDTH-1:0] w_presc_nxt;
    logic                 r_pending;
    logic                 w_pending_nxt;
    logic                 r_enable;
    logic                 w_enable_nxt;
    logic                 r_swap;
    logic                 w_swap_nxt;
    logic                 r_running;

`ifdef Q1CTRL_STEP_EN
    assign w_raw = {stepBtn, swapBtn, startStopBtn};
`else
    assign w_raw = {swapBtn, startStopBtn};
`endif

    // Two-flop synchroniser, then a per-button counter of consecutive disagreeing cycles.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < NB; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_cnt[i] <= '0;
                    r_deb[i]     <= ~r_deb[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the single cycle in which the debounced level has just risen.
    assign w_press    = r_deb & ~r_deb_d;
    assign w_ss_press = w_press[BTN_SS];
    assign w_sw_press = w_press[BTN_SW];
`ifdef Q1CTRL_STEP_EN
    assign w_step_press = w_press[2];
`else
    assign w_step_press = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state   <= ST_STOPPED;
            r_presc   <= '0;
            r_pending <= 1'b0;
            r_enable  <= 1'b0;
            r_swap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_pending <= w_pending_nxt;
            r_enable  <= w_enable_nxt;
            r_swap    <= w_swap_nxt;
            r_running <= (w_state_nxt == ST_RUNNING);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_pending_nxt = r_pending;
        w_enable_nxt  = 1'b0;
        w_swap_nxt    = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                w_presc_nxt   = '0;
                w_pending_nxt = 1'b0;
                if (w_ss_press) begin
                    // A swap pressed together with start waits for the first tick.
                    w_state_nxt   = ST_RUNNING;
                    w_pending_nxt = w_sw_press;
                end else if (w_sw_press || w_step_press) begin
                    w_enable_nxt = 1'b1;
                    w_swap_nxt   = w_sw_press;
                end
            end
            ST_RUNNING: begin
                if (w_ss_press) begin
                    w_state_nxt   = ST_STOPPED;
                    w_presc_nxt   = '0;
                    w_pending_nxt = 1'b0;
                end else if (r_presc == PRESC_LAST) begin
                    // A swap landing on a tick edge is held over to the next tick.
                    w_presc_nxt   = '0;
                    w_enable_nxt  = 1'b1;
                    w_swap_nxt    = r_pending;
                    w_pending_nxt = w_sw_press;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                    if (w_sw_press) begin
                        w_pending_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
            end
        endcase
    end

    assign enable  = r_enable;
    assign swap    = r_swap;
    assign running = r_running;

endmodule

// File: tb/tb_q1_control.sv
// Self-checking bench for q1_control with D=4, T=5: directed scenarios plus random button
// traffic, all compared against an event-level reference model of the press/run/tick rules.
module tb_q1_control;
    localparam int D = 4;
    localparam int T = 5;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    logic startStopBtn = 1'b0;
    logic swapBtn = 1'b0;
    logic enable;
    logic swap;
    logic running;

    int checks = 0;
    int errors = 0;

    q1_control #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV(T),
        .CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .startStopBtn(startStopBtn),
        .swapBtn(swapBtn),
        .enable(enable),
        .swap(swap),
        .running(running)
    );

    always #5 clock = ~clock;

    // Reference model: a level is accepted once the synced input has disagreed with it for the
    // last D samples; ticks fall every T edges after entering RUNNING.
    int cyc = 0;
    int m_entry = 0;
    bit m_en, m_sw, m_run, m_pend;
    bit m_deb [2];
    bit m_pr [2];
    bit m_s1 [2];
    bit m_hist [2][D];

    always @(posedge clock) begin
        bit raw [2];
        bit ss, sw, all_diff;
        cyc++;
        raw[0] = startStopBtn;
        raw[1] = swapBtn;
        if (resetN !== 1'b1) begin
            m_en = 0; m_sw = 0; m_run = 0; m_pend = 0; m_entry = 0;
            for (int b = 0; b < 2; b++) begin
                m_deb[b] = 0; m_pr[b] = 0; m_s1[b] = 0;
                for (int i = 0; i < D; i++) m_hist[b][i] = 0;
            end
        end else begin
            ss = m_pr[0];
            sw = m_pr[1];
            m_en = 0;
            m_sw = 0;
            if (!m_run) begin
                if (ss) begin
                    m_run = 1; m_entry = cyc; m_pend = sw;
                end else if (sw) begin
                    m_en = 1; m_sw = 1;
                end
            end else if (ss) begin
                m_run = 0; m_pend = 0;
            end else if ((cyc - m_entry) % T == 0) begin
                m_en = 1; m_sw = m_pend; m_pend = sw;
            end else if (sw) begin
                m_pend = 1;
            end
            for (int b = 0; b < 2; b++) begin
                all_diff = 1;
                for (int i = 0; i < D; i++) if (m_hist[b][i] == m_deb[b]) all_diff = 0;
                m_pr[b] = 0;
                if (all_diff) begin
                    m_deb[b] = !m_deb[b];
                    m_pr[b] = m_deb[b];
                end
                for (int i = 0; i < D - 1; i++) m_hist[b][i] = m_hist[b][i+1];
                m_hist[b][D-1] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    task automatic apply_reset();
        startStopBtn = 0;
        swapBtn = 0;
        resetN = 0;
        repeat (2) @(negedge clock);
        resetN = 1;
    endtask

    task automatic test_reset();
        int k, jj;
        resetN = 0;
        for (int i = 0; i < 3; i++) begin
            startStopBtn = 1'($urandom_range(0, 1));
            swapBtn = 1'($urandom_range(0, 1));
            @(negedge clock);
            checks++;
            if ({enable, swap, running} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got en/sw/run=%b%b%b want 000", cyc, enable, swap, running);
            end
        end
        startStopBtn = 1;
        swapBtn = 0;
        resetN = 1;
        k = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            jj = cyc - k;
            checks++;
            if (running !== (jj >= D + 2)) begin
                errors++;
                $display("FAIL reset_first_press edge=k+%0d got running=%b want %b", jj, running, (jj >= D + 2));
            end
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
        startStopBtn = 0;
    endtask

    task automatic test_start();
        int k, jj;
        bit exp_en;
        apply_reset();
        repeat (3) @(negedge clock);
        startStopBtn = 1;
        k = cyc + 1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clock);
            jj = cyc - k;
            exp_en = (jj == D + 2 + T) || (jj == D + 2 + 2 * T) || (jj == D + 2 + 3 * T);
            checks++;
            if (running !== (jj >= D + 2) || enable !== exp_en) begin
                errors++;
                $display("FAIL start edge=k+%0d got run/en=%b%b want %b%b", jj, running, enable, (jj >= D + 2), exp_en);
            end
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL start_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
        startStopBtn = 0;
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            startStopBtn = (i < 20) ? 1'(((i / 2) % 2) == 0) : 1'b0;
            @(negedge clock);
            checks++;
            if (running !== 1'b0 || enable !== 1'b0) begin
                errors++;
                $display("FAIL bounce i=%0d got run/en=%b%b want 00", i, running, enable);
            end
        end
    endtask

    task automatic test_queued_swap();
        int swaps = 0;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            startStopBtn = (i < 8);
            swapBtn = (i >= 22 && i < 30);
            @(negedge clock);
            if (enable === 1'b1 && swap === 1'b1) swaps++;
            if (i == 31 || i == 36) begin
                checks++;
                if ({enable, swap} !== {1'b1, (i == 31)}) begin
                    errors++;
                    $display("FAIL queued_swap i=%0d got en/sw=%b%b want 1%b", i, enable, swap, (i == 31));
                end
            end
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL queued_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
        checks++;
        if (swaps != 1) begin
            errors++;
            $display("FAIL queued_swap_count got %0d want 1", swaps);
        end
    endtask

    task automatic test_three_swaps();
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            startStopBtn = (i < 8);
            swapBtn = (i >= 20 && i < 25) || (i >= 30 && i < 35) || (i >= 40 && i < 45);
            @(negedge clock);
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL three_swaps cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
    endtask

    task automatic test_stop_swap();
        bit seen = 0;
        apply_reset();
        for (int i = 0; i < 70; i++) begin
            startStopBtn = (i < 8) || (i >= 20 && i < 28);
            swapBtn = (i >= 20 && i < 28);
            @(negedge clock);
            if (i >= 20 && swap === 1'b1) seen = 1;
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL stop_swap_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
        checks++;
        if (running !== 1'b0 || seen) begin
            errors++;
            $display("FAIL stop_swap got running=%b swap_seen=%b want 0 0", running, seen);
        end
    endtask

    task automatic test_stopped_swap();
        int k, jj, ens = 0, sws = 0;
        apply_reset();
        @(negedge clock);
        swapBtn = 1;
        k = cyc + 1;
        for (int j = 0; j < 30; j++) begin
            if (j == 8) swapBtn = 0;
            @(negedge clock);
            jj = cyc - k;
            if (enable === 1'b1) ens++;
            if (swap === 1'b1) sws++;
            checks++;
            if ({enable, swap} !== {2{jj == D + 2}} || running !== 1'b0) begin
                errors++;
                $display("FAIL stopped_swap edge=k+%0d got en/sw/run=%b%b%b want %b%b0", jj, enable, swap, running, (jj == D + 2), (jj == D + 2));
            end
        end
        checks++;
        if (ens != 1 || sws != 1) begin
            errors++;
            $display("FAIL stopped_swap_count got en=%0d sw=%0d want 1 1", ens, sws);
        end
    endtask

    task automatic test_mid_reset();
        int k, jj;
        bit got_pend = 0;
        apply_reset();
        for (int i = 0; i < 60 && !got_pend; i++) begin
            startStopBtn = (i < 8);
            swapBtn = (i >= 22 && i < 30);
            @(negedge clock);
            got_pend = m_pend;
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL mid_reset_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
        end
        checks++;
        if (!got_pend) begin
            errors++;
            $display("FAIL mid_reset_setup got pending=0 want 1");
        end
        startStopBtn = 0;
        swapBtn = 0;
        resetN = 0;
        repeat (2) @(negedge clock);
        resetN = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++;
            if ({enable, swap, running} !== 3'b000) begin
                errors++;
                $display("FAIL mid_reset_after i=%0d got %b%b%b want 000", i, enable, swap, running);
            end
        end
        startStopBtn = 1;
        k = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            jj = cyc - k;
            checks++;
            if (running !== (jj >= D + 2) || swap !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_restart edge=k+%0d got run/sw=%b%b want %b0", jj, running, swap, (jj >= D + 2));
            end
        end
        startStopBtn = 0;
    endtask

    task automatic test_random();
        int hold_ss = 0, hold_sw = 0;
        bit prev_en = 0;
        apply_reset();
        for (int i = 0; i < 2500; i++) begin
            if (hold_ss == 0) begin
                startStopBtn = 1'($urandom_range(0, 1));
                hold_ss = int'($urandom_range(1, 14));
            end
            if (hold_sw == 0) begin
                swapBtn = 1'($urandom_range(0, 1));
                hold_sw = int'($urandom_range(1, 12));
            end
            hold_ss--;
            hold_sw--;
            resetN = ($urandom_range(0, 299) != 0);
            @(negedge clock);
            checks++;
            if ({enable, swap, running} !== {m_en, m_sw, m_run}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got %b%b%b want %b%b%b", cyc, enable, swap, running, m_en, m_sw, m_run);
            end
            checks++;
            if ((swap === 1'b1 && enable !== 1'b1) || (enable === 1'b1 && prev_en)) begin
                errors++;
                $display("FAIL random_strobe cyc=%0d got en/sw=%b%b prev_en=%b", cyc, enable, swap, prev_en);
            end
            prev_en = (enable === 1'b1);
        end
        resetN = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d timeout", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_queued_swap();
        test_three_swaps();
        test_stop_swap();
        test_stopped_swap();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
